// File: rtl/execute_hazard_controller_pkg.sv
// Shared pipeline package for the execute-stage hazard controller.
// Holds the controller state encoding, the pipeline NOP word used when
// younger instructions are squashed, and a saturating counter helper.
package execute_hazard_controller_pkg;

  // Controller state encoding; value 2'd3 is never entered on purpose.
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } hz_state_e;

  // Instruction word substituted for squashed fetch/decode slots (mov r0,r0).
  localparam logic [31:0] NOP_INSTR = 32'hE1A0_0000;

  localparam logic [15:0] STALL_COUNT_MAX = 16'hFFFF;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == STALL_COUNT_MAX) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/execute_hazard_controller_hazard_detect.sv
// hazard_detect: load-use register comparator.
// Flags the case where the execute stage holds a load whose destination is
// read by the instruction currently in decode.
//   dec_valid, dec_rn/rs/rm, dec_use : decode-stage operand info
//   ex_valid, ex_rd, ex_is_load      : execute-stage destination info
//   load_use                         : decode must wait one cycle
module hazard_detect
  import execute_hazard_controller_pkg::*;
(
  input  logic       dec_valid,
  input  logic [3:0] dec_rn,
  input  logic [3:0] dec_rs,
  input  logic [3:0] dec_rm,
  input  logic [2:0] dec_use,
  input  logic       ex_valid,
  input  logic       ex_is_load,
  input  logic [3:0] ex_rd,
  output logic       load_use
);

  logic [2:0] match_s;

  // Per-operand match, qualified by whether that operand is actually read.
  always_comb begin
    match_s[0] = dec_use[0] & (dec_rn == ex_rd);
    match_s[1] = dec_use[1] & (dec_rs == ex_rd);
    match_s[2] = dec_use[2] & (dec_rm == ex_rd);
    load_use   = ex_valid & ex_is_load & dec_valid & (|match_s);
  end

endmodule

// File: rtl/execute_hazard_controller.sv
// execute_hazard_controller: stall/flush sequencing for the execute stage.
// Detects load-use hazards, holds the pipe while memory is busy (with a
// bounded wait), and squashes younger instructions after a taken branch.
//   clk, rst (async, active high)
//   dec_* / ex_*            : stage contents for hazard detection
//   branch_taken            : execute resolved a taken branch
//   mem_req, mem_ack        : memory stage handshake
//   stall, flush            : combinational pipeline controls (mutually exclusive)
//   state_o                 : current controller state
//   stall_count             : saturating count of stalled cycles
//   mem_timeout             : sticky flag, a memory wait gave up
module execute_hazard_controller
  import execute_hazard_controller_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dec_valid,
  input  logic [3:0]  dec_rn,
  input  logic [3:0]  dec_rs,
  input  logic [3:0]  dec_rm,
  input  logic [2:0]  dec_use,
  input  logic        ex_valid,
  input  logic [3:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        stall,
  output logic        flush,
  output logic [1:0]  state_o,
  output logic [15:0] stall_count,
  output logic        mem_timeout
);

  // Flush counter starts at FLUSH_CYCLES-1 because the branch cycle itself
  // already flushes; the wait counter's last legal value is MEM_TIMEOUT-1.
  localparam logic [2:0] FLUSH_INIT_C   = 3'(FLUSH_CYCLES - 1);
  localparam logic [3:0] TIMEOUT_LAST_C = 4'(MEM_TIMEOUT - 1);
  localparam logic       FLUSH_MULTI_C  = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;

  hz_state_e   state_r;
  hz_state_e   state_nxt_s;
  logic [3:0]  wait_cnt_r;
  logic [3:0]  wait_cnt_nxt_s;
  logic [2:0]  flush_cnt_r;
  logic [2:0]  flush_cnt_nxt_s;
  logic [15:0] stall_count_r;
  logic        mem_timeout_r;
  logic        timeout_hit_s;
  logic        load_use_s;
  logic        mem_block_s;
  logic        branch_s;
  logic        stall_s;
  logic        flush_s;

  hazard_detect u_hazard_detect (
    .dec_valid  (dec_valid),
    .dec_rn     (dec_rn),
    .dec_rs     (dec_rs),
    .dec_rm     (dec_rm),
    .dec_use    (dec_use),
    .ex_valid   (ex_valid),
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .load_use   (load_use_s)
  );

  assign mem_block_s = mem_req & ~mem_ack;
  assign branch_s    = branch_taken & ex_valid;

  // State and counter registers, plus the stall statistics and sticky timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_RUN;
      wait_cnt_r    <= 4'd0;
      flush_cnt_r   <= 3'd0;
      stall_count_r <= 16'd0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      flush_cnt_r <= flush_cnt_nxt_s;
      if (stall_s) begin
        stall_count_r <= sat_inc16(stall_count_r);
      end
      if (timeout_hit_s) begin
        mem_timeout_r <= 1'b1;
      end
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_nxt_s     = ST_RUN;
    wait_cnt_nxt_s  = wait_cnt_r;
    flush_cnt_nxt_s = flush_cnt_r;
    timeout_hit_s   = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (mem_block_s) begin
          state_nxt_s    = ST_MEM_WAIT;
          wait_cnt_nxt_s = 4'd0;
        end else if (branch_s && FLUSH_MULTI_C) begin
          state_nxt_s     = ST_FLUSH;
          flush_cnt_nxt_s = FLUSH_INIT_C;
        end else begin
          // Single-cycle flush or load-use bubble both stay in RUN.
          state_nxt_s = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          if (branch_s && FLUSH_MULTI_C) begin
            state_nxt_s     = ST_FLUSH;
            flush_cnt_nxt_s = FLUSH_INIT_C;
          end else begin
            state_nxt_s = ST_RUN;
          end
          wait_cnt_nxt_s = 4'd0;
        end else if (wait_cnt_r == TIMEOUT_LAST_C) begin
          // This is the MEM_TIMEOUT-th waiting cycle: give up.
          timeout_hit_s  = 1'b1;
          state_nxt_s    = ST_RUN;
          wait_cnt_nxt_s = 4'd0;
        end else begin
          state_nxt_s    = ST_MEM_WAIT;
          wait_cnt_nxt_s = wait_cnt_r + 4'd1;
        end
      end
      ST_FLUSH: begin
        if (mem_block_s) begin
          // Memory stall wins; the rest of the flush is dropped.
          state_nxt_s     = ST_MEM_WAIT;
          wait_cnt_nxt_s  = 4'd0;
          flush_cnt_nxt_s = 3'd0;
        end else if (flush_cnt_r <= 3'd1) begin
          state_nxt_s     = ST_RUN;
          flush_cnt_nxt_s = 3'd0;
        end else begin
          state_nxt_s     = ST_FLUSH;
          flush_cnt_nxt_s = flush_cnt_r - 3'd1;
        end
      end
      default: begin
        // Unused encoding: recover to RUN with clean counters.
        state_nxt_s     = ST_RUN;
        wait_cnt_nxt_s  = 4'd0;
        flush_cnt_nxt_s = 3'd0;
      end
    endcase
  end

  // Stall/flush outputs; each branch drives at most one of them.
  always_comb begin
    stall_s = 1'b0;
    flush_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (mem_block_s) begin
          stall_s = 1'b1;
        end else if (branch_s) begin
          flush_s = 1'b1;
        end else if (load_use_s) begin
          stall_s = 1'b1;
        end else begin
          stall_s = 1'b0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          flush_s = branch_s;
        end else if (wait_cnt_r == TIMEOUT_LAST_C) begin
          stall_s = 1'b0;
        end else begin
          stall_s = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (mem_block_s) begin
          stall_s = 1'b1;
        end else begin
          flush_s = 1'b1;
        end
      end
      default: begin
        stall_s = 1'b0;
        flush_s = 1'b0;
      end
    endcase
  end

  assign stall       = stall_s;
  assign flush       = flush_s;
  assign state_o     = state_r;
  assign stall_count = stall_count_r;
  assign mem_timeout = mem_timeout_r;

endmodule

// File: tb/tb_execute_hazard_controller.sv
// Directed testbench for execute_hazard_controller (default parameters).
module tb_execute_hazard_controller;

  logic        clk;
  logic        rst;
  logic        dec_valid;
  logic [3:0]  dec_rn;
  logic [3:0]  dec_rs;
  logic [3:0]  dec_rm;
  logic [2:0]  dec_use;
  logic        ex_valid;
  logic [3:0]  ex_rd;
  logic        ex_is_load;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ack;
  logic        stall;
  logic        flush;
  logic [1:0]  state_o;
  logic [15:0] stall_count;
  logic        mem_timeout;

  int n_cmp;
  int n_fail;

  execute_hazard_controller dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_rn       (dec_rn),
    .dec_rs       (dec_rs),
    .dec_rm       (dec_rm),
    .dec_use      (dec_use),
    .ex_valid     (ex_valid),
    .ex_rd        (ex_rd),
    .ex_is_load   (ex_is_load),
    .branch_taken (branch_taken),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .stall        (stall),
    .flush        (flush),
    .state_o      (state_o),
    .stall_count  (stall_count),
    .mem_timeout  (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    dec_valid = 1'b0; dec_rn = 4'd0; dec_rs = 4'd0; dec_rm = 4'd0; dec_use = 3'd0;
    ex_valid = 1'b0; ex_rd = 4'd0; ex_is_load = 1'b0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", state_o); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %0b want 0", stall); end
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %0b want 0", flush); end
    n_cmp++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", stall_count); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_timeout: got %0b want 0", mem_timeout); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd3;
    dec_valid = 1'b1; dec_rn = 4'd1; dec_rs = 4'd2; dec_rm = 4'd3; dec_use = 3'b100;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %0b want 1", stall); end
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL lu_flush: got %0b want 0", flush); end
    cyc();
    // Load has advanced; decode now sees a plain ALU op in execute.
    ex_is_load = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_one_cycle: got %0b want 0", stall); end
    n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL lu_state: got %0d want 0", state_o); end
    n_cmp++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_count: got %0d want 1", stall_count); end
  endtask

  // Operand-select variants, all checked combinationally inside one cycle.
  task automatic test_load_use_variants();
    do_reset();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 4'd3;
    dec_valid = 1'b1; dec_rn = 4'd3; dec_rs = 4'd3; dec_rm = 4'd3; dec_use = 3'b000;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_unused: got %0b want 0", stall); end
    dec_use = 3'b100; ex_is_load = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_not_load: got %0b want 0", stall); end
    ex_is_load = 1'b1; dec_use = 3'b001; dec_rs = 4'd7; dec_rm = 4'd8;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_rn: got %0b want 1", stall); end
    dec_use = 3'b010; dec_rn = 4'd9; dec_rs = 4'd3;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_rs: got %0b want 1", stall); end
    dec_valid = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_dec_invalid: got %0b want 0", stall); end
    dec_valid = 1'b1; dec_use = 3'b111; dec_rn = 4'd4; dec_rs = 4'd5; dec_rm = 4'd6;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_no_match: got %0b want 0", stall); end
    clear_inputs();
    cyc();
    n_cmp++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL lu_var_count: got %0d want 0", stall_count); end
  endtask

  task automatic test_mem_wait();
    do_reset();
    mem_req = 1'b1; mem_ack = 1'b0;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mw_run_stall: got %0b want 1", stall); end
    n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL mw_run_state: got %0d want 0", state_o); end
    cyc();
    for (int i = 1; i <= 4; i++) begin
      n_cmp++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL mw_state_%0d: got %0d want 1", i, state_o); end
      n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mw_stall_%0d: got %0b want 1", i, stall); end
      cyc();
    end
    mem_ack = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mw_ack_stall: got %0b want 0", stall); end
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL mw_ack_flush: got %0b want 0", flush); end
    cyc();
    mem_req = 1'b0; mem_ack = 1'b0;
    #1;
    n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL mw_after_state: got %0d want 0", state_o); end
    n_cmp++; if (stall_count !== 16'd5) begin n_fail++; $display("FAIL mw_count: got %0d want 5", stall_count); end
  endtask

  task automatic test_branch();
    do_reset();
    branch_taken = 1'b1; ex_valid = 1'b0;
    #1;
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL br_no_valid: got %0b want 0", flush); end
    ex_valid = 1'b1;
    #1;
    n_cmp++; if (flush !== 1'b1) begin n_fail++; $display("FAIL br_flush1: got %0b want 1", flush); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL br_stall1: got %0b want 0", stall); end
    cyc();
    // Branch still high and a load-use present: both ignored during FLUSH.
    ex_is_load = 1'b1; ex_rd = 4'd2; dec_valid = 1'b1; dec_rn = 4'd2; dec_use = 3'b001;
    #1;
    n_cmp++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL br_state_flush: got %0d want 2", state_o); end
    n_cmp++; if (flush !== 1'b1) begin n_fail++; $display("FAIL br_flush2: got %0b want 1", flush); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL br_stall2: got %0b want 0", stall); end
    cyc();
    clear_inputs();
    #1;
    n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL br_state_after: got %0d want 0", state_o); end
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL br_flush3: got %0b want 0", flush); end
    n_cmp++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL br_count: got %0d want 0", stall_count); end
  endtask

  task automatic test_priority();
    do_reset();
    mem_req = 1'b1; branch_taken = 1'b1; ex_valid = 1'b1;
    ex_is_load = 1'b1; ex_rd = 4'd5; dec_valid = 1'b1; dec_rm = 4'd5; dec_use = 3'b100;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL pr_stall: got %0b want 1", stall); end
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL pr_flush: got %0b want 0", flush); end
    cyc();
    mem_ack = 1'b1;
    #1;
    n_cmp++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL pr_state_mw: got %0d want 1", state_o); end
    n_cmp++; if (flush !== 1'b1) begin n_fail++; $display("FAIL pr_ack_flush: got %0b want 1", flush); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL pr_ack_stall: got %0b want 0", stall); end
    cyc();
    clear_inputs();
    #1;
    n_cmp++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL pr_state_flush: got %0d want 2", state_o); end
    n_cmp++; if (flush !== 1'b1) begin n_fail++; $display("FAIL pr_flush2: got %0b want 1", flush); end
    cyc();
    n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL pr_state_run: got %0d want 0", state_o); end
    n_cmp++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL pr_count: got %0d want 1", stall_count); end
  endtask

  task automatic test_flush_then_mem();
    do_reset();
    branch_taken = 1'b1; ex_valid = 1'b1;
    cyc();
    branch_taken = 1'b0; mem_req = 1'b1;
    #1;
    n_cmp++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL fm_state: got %0d want 2", state_o); end
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL fm_stall: got %0b want 1", stall); end
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL fm_flush: got %0b want 0", flush); end
    cyc();
    mem_ack = 1'b1;
    #1;
    n_cmp++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL fm_state_mw: got %0d want 1", state_o); end
    cyc();
    clear_inputs();
    #1;
    n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL fm_state_run: got %0d want 0", state_o); end
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL fm_no_residual: got %0b want 0", flush); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_req = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL to_run_stall: got %0b want 1", stall); end
    cyc();
    for (int i = 1; i <= 14; i++) begin
      n_cmp++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL to_state_%0d: got %0d want 1", i, state_o); end
      n_cmp++; if (stall !== 1'b1) begin n_fail++; $display("FAIL to_stall_%0d: got %0b want 1", i, stall); end
      cyc();
    end
    // Fifteenth waiting cycle: the controller gives up here.
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL to_last_stall: got %0b want 0", stall); end
    n_cmp++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_early: got %0b want 0", mem_timeout); end
    cyc();
    n_cmp++; if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %0b want 1", mem_timeout); end
    n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL to_state_run: got %0d want 0", state_o); end
    mem_req = 1'b0;
    cyc();
    cyc();
    n_cmp++; if (mem_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %0b want 1", mem_timeout); end
    n_cmp++; if (stall_count !== 16'd15) begin n_fail++; $display("FAIL to_count: got %0d want 15", stall_count); end
    rst = 1'b1;
    #1;
    n_cmp++; if (mem_timeout !== 1'b0) begin n_fail++; $display("FAIL to_rst_clear: got %0b want 0", mem_timeout); end
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    mem_req = 1'b1; branch_taken = 1'b1; ex_valid = 1'b1;
    cyc();
    cyc();
    n_cmp++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL rm_pre_state: got %0d want 1", state_o); end
    mem_req = 1'b0;
    rst = 1'b1;
    #1;
    n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL rm_state: got %0d want 0", state_o); end
    n_cmp++; if (stall_count !== 16'd0) begin n_fail++; $display("FAIL rm_count: got %0d want 0", stall_count); end
    branch_taken = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rm_flush1: got %0b want 0", flush); end
    n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall1: got %0b want 0", stall); end
    cyc();
    n_cmp++; if (flush !== 1'b0) begin n_fail++; $display("FAIL rm_flush2: got %0b want 0", flush); end
    n_cmp++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL rm_state2: got %0d want 0", state_o); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    clear_inputs();
    cyc();
    test_reset();
    test_load_use();
    test_load_use_variants();
    test_mem_wait();
    test_branch();
    test_priority();
    test_flush_then_mem();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
